// File: rtl/mul8_pkg.sv
// mul8_pkg: shared states, shift codes and sizes for the 8x8 nibble-serial multiplier
package mul8_pkg;
  localparam int W = 8;
  localparam int NIB = 4;
  localparam int STEPS = 4;
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  localparam logic [1:0] SH0 = 2'b00;
  localparam logic [1:0] SH4 = 2'b01;
  localparam logic [1:0] SH8 = 2'b10;
  localparam logic [1:0] SH_ILL = 2'b11;
endpackage

// File: rtl/mul4x4.sv
// mul4x4: combinational unsigned NxN multiplier with a 2N-bit product
module mul4x4 #(
  parameter int N = mul8_pkg::NIB
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] p
);
  assign p = x * y;
endmodule

// File: rtl/mul8_accum.sv
// mul8_accum: shifted 4x4 partial-product accumulator for an 8x8 multiply; MUL8_ACC_STEP_CHECK_EN adds step-pair checking
module mul8_accum #(
  parameter int W = 8,
  parameter int NIB = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           st,
  input  logic           step,
  input  logic           input_sela,
  input  logic           input_selb,
  input  logic [1:0]     shift_sel,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           prod_valid,
  output logic           busy,
  output logic [2:0]     step_cnt,
  output logic           err
);
  import mul8_pkg::*;
  state_t state;
  logic [W-1:0] a_q, b_q;
  logic [2*W-1:0] acc, pp16, term, sum;
  logic [NIB-1:0] na, nb;
  logic [2*NIB-1:0] pp;
  logic bad;
  logic [1:0] pair;
  assign na = input_sela ? a_q[W-1:NIB] : a_q[NIB-1:0];
  assign nb = input_selb ? b_q[W-1:NIB] : b_q[NIB-1:0];
  assign pair = {input_sela, input_selb};
  mul4x4 #(.N(NIB)) u_mul (.x(na), .y(nb), .p(pp));
  always_comb begin
    pp16 = {{(2*W-2*NIB){1'b0}}, pp};
    term = shift_sel == SH0 ? pp16 :
           shift_sel == SH4 ? pp16 << 4 :
           shift_sel == SH8 ? pp16 << 8 : '0;
    sum = acc + term;
  end
`ifdef MUL8_ACC_STEP_CHECK_EN
  logic [3:0] seen;
  logic [1:0] exp_sh;
  assign exp_sh = pair == 2'b00 ? SH0 : pair == 2'b11 ? SH8 : SH4;
  assign bad = seen[pair] || shift_sel != exp_sh;
  always_ff @(posedge clk)
    seen <= rst || (st && state != ACC) ? '0 :
            state == ACC && step ? seen | (4'b1 << pair) : seen;
`else
  assign bad = shift_sel == SH_ILL;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      a_q <= '0;
      b_q <= '0;
      product <= '0;
      prod_valid <= 1'b0;
      busy <= 1'b0;
      step_cnt <= '0;
      err <= 1'b0;
    end else if (state != ACC) begin
      if (st) begin
        a_q <= a;
        b_q <= b;
        acc <= '0;
        step_cnt <= '0;
        prod_valid <= 1'b0;
        err <= 1'b0;
        busy <= 1'b1;
        state <= ACC;
      end
    end else if (step) begin
      acc <= sum;
      step_cnt <= step_cnt + 3'd1;
      err <= err | bad;
      if (step_cnt == 3'(STEPS - 1)) begin
        product <= sum;
        prod_valid <= 1'b1;
        busy <= 1'b0;
        state <= HOLD;
      end
    end
  end
endmodule

// File: tb/tb_mul8_accum.sv
// tb_mul8_accum: directed vector table and corner sequences for mul8_accum
module tb_mul8_accum;
  logic clk = 1'b0, rst = 1'b1, st = 1'b0, step = 1'b0, input_sela = 1'b0, input_selb = 1'b0;
  logic [1:0] shift_sel = 2'b00;
  logic [7:0] a = '0, b = '0;
  logic [15:0] product;
  logic prod_valid, busy, err;
  logic [2:0] step_cnt;
  int checks = 0, failures = 0;
`ifdef MUL8_ACC_STEP_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  typedef struct {
    logic [7:0] a, b;
    logic [3:0][1:0] pr;
    logic [3:0][1:0] sh;
    int gap;
    logic [15:0] prod;
    logic err;
  } vec_t;
  vec_t v[6];
  mul8_accum dut (
    .clk(clk), .rst(rst), .st(st), .step(step), .input_sela(input_sela),
    .input_selb(input_selb), .shift_sel(shift_sel), .a(a), .b(b),
    .product(product), .prod_valid(prod_valid), .busy(busy),
    .step_cnt(step_cnt), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_step(input logic [1:0] pr, input logic [1:0] sh);
    step = 1'b1;
    {input_sela, input_selb} = pr;
    shift_sel = sh;
    tick();
    step = 1'b0;
  endtask
  task automatic start(input logic [7:0] av, input logic [7:0] bv);
    a = av;
    b = bv;
    st = 1'b1;
    tick();
    st = 1'b0;
  endtask
  task automatic run(input vec_t t, input string nm);
    start(t.a, t.b);
    chk({nm, "_st_busy"}, 32'(busy), 1);
    chk({nm, "_st_valid"}, 32'(prod_valid), 0);
    chk({nm, "_st_cnt"}, 32'(step_cnt), 0);
    chk({nm, "_st_err"}, 32'(err), 0);
    for (int i = 0; i < 4; i++) begin
      do_step(t.pr[i], t.sh[i]);
      chk({nm, "_cnt"}, 32'(step_cnt), i + 1);
      chk({nm, "_valid"}, 32'(prod_valid), 32'(i == 3));
      if (i < 3)
        for (int g = 0; g < t.gap; g++) begin
          tick();
          chk({nm, "_gap_busy"}, 32'(busy), 1);
          chk({nm, "_gap_cnt"}, 32'(step_cnt), i + 1);
        end
    end
    chk({nm, "_product"}, 32'(product), 32'(t.prod));
    chk({nm, "_err"}, 32'(err), 32'(t.err));
    chk({nm, "_end_busy"}, 32'(busy), 0);
  endtask
  initial begin
    v[0] = '{8'hAB, 8'hCD, {2'b11, 2'b10, 2'b01, 2'b00}, {2'b10, 2'b01, 2'b01, 2'b00}, 0, 16'h88EF, 1'b0};
    v[1] = '{8'hFF, 8'hFF, {2'b11, 2'b10, 2'b01, 2'b00}, {2'b10, 2'b01, 2'b01, 2'b00}, 0, 16'hFE01, 1'b0};
    v[2] = '{8'h00, 8'h5A, {2'b11, 2'b10, 2'b01, 2'b00}, {2'b10, 2'b01, 2'b01, 2'b00}, 0, 16'h0000, 1'b0};
    v[3] = '{8'h12, 8'h34, {2'b01, 2'b10, 2'b00, 2'b11}, {2'b01, 2'b01, 2'b00, 2'b10}, 3, 16'h03A8, 1'b0};
    v[4] = '{8'hAB, 8'hCD, {2'b11, 2'b10, 2'b01, 2'b00}, {2'b11, 2'b01, 2'b01, 2'b00}, 0, 16'h10EF, 1'b1};
    v[5] = '{8'h12, 8'h34, {2'b10, 2'b01, 2'b00, 2'b00}, {2'b01, 2'b01, 2'b00, 2'b00}, 0, 16'h00B0, CHK};
    tick();
    tick();
    rst = 1'b0;
    chk("rst_product", 32'(product), 0);
    chk("rst_valid", 32'(prod_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(step_cnt), 0);
    chk("rst_err", 32'(err), 0);
    do_step(2'b00, 2'b00);
    chk("idle_step_cnt", 32'(step_cnt), 0);
    chk("idle_step_busy", 32'(busy), 0);
    for (int k = 0; k < 6; k++) run(v[k], $sformatf("vec%0d", k));
    start(8'hAB, 8'hCD);
    do_step(2'b00, 2'b00);
    do_step(2'b01, 2'b01);
    chk("mid_cnt", 32'(step_cnt), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_product", 32'(product), 0);
    chk("midrst_valid", 32'(prod_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_cnt", 32'(step_cnt), 0);
    chk("midrst_err", 32'(err), 0);
    run(v[0], "pre");
    v[0].a = 8'h0F;
    v[0].b = 8'h0F;
    v[0].prod = 16'h00E1;
    run(v[0], "after_rst");
    start(8'h12, 8'h34);
    do_step(2'b00, 2'b00);
    a = 8'hFF;
    b = 8'hFF;
    st = 1'b1;
    tick();
    st = 1'b0;
    chk("acc_st_cnt", 32'(step_cnt), 1);
    chk("acc_st_busy", 32'(busy), 1);
    do_step(2'b01, 2'b01);
    do_step(2'b10, 2'b01);
    do_step(2'b11, 2'b10);
    chk("acc_st_product", 32'(product), 32'h03A8);
    chk("acc_st_valid", 32'(prod_valid), 1);
    a = 8'h0F;
    b = 8'h0F;
    st = 1'b1;
    step = 1'b1;
    {input_sela, input_selb} = 2'b00;
    shift_sel = 2'b00;
    tick();
    st = 1'b0;
    step = 1'b0;
    chk("hold_ststep_cnt", 32'(step_cnt), 0);
    chk("hold_ststep_busy", 32'(busy), 1);
    chk("hold_ststep_valid", 32'(prod_valid), 0);
    chk("hold_ststep_product", 32'(product), 32'h03A8);
    do_step(2'b00, 2'b00);
    do_step(2'b01, 2'b01);
    do_step(2'b10, 2'b01);
    do_step(2'b11, 2'b10);
    chk("restart_product", 32'(product), 32'h00E1);
    chk("restart_cnt", 32'(step_cnt), 4);
    chk("restart_err", 32'(err), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
